nasti_slave_arbiter: RTL and testbench
======================================

Name: nasti_slave_arbiter

Overview:
- Shares the single FPGA-to-PS NASTI/AXI slave port (64-bit HP path into the DDR controller) between two requesters.
- Requester 0 is the simulation memory model; requester 1 is the host DMA/trace engine.
- AR and AW are granted round-robin. The W stream follows AW grant order through a small routing FIFO.
- R and B responses are steered back to the issuing requester by one ID bit the block prepends.
- Sits between the shim's slave-side NASTI bundle and the address-remap/system slave port.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 64, R/W data width.
- ID_W, 5, requester ID width; downstream ID is ID_W+1 bits.
- WQ_DEPTH, 4, entries in the W routing FIFO; must be a power of 2, minimum 2.

Ports:
- clk  in  1  block clock.
- reset  in  1  synchronous, active-high.
- mN_ar_{valid,ready,addr,id,len,size}  in/out/in/in/in/in  1/1/ADDR_W/ID_W/8/3  read address from requester N (N=0,1).
- mN_aw_{valid,ready,addr,id,len,size}  in/out/in/in/in/in  1/1/ADDR_W/ID_W/8/3  write address from requester N.
- mN_w_{valid,ready,data,last}  in/out/in/in  1/1/DATA_W/1  write data from requester N.
- mN_b_{valid,ready,id,resp}  out/in/out/out  1/1/ID_W/2  write response to requester N.
- mN_r_{valid,ready,data,id,resp,last}  out/in/out/out/out/out  1/1/DATA_W/ID_W/2/1  read data to requester N.
- s_ar_{valid,ready,addr,id,len,size}  out/in/out/out/out/out  1/1/ADDR_W/ID_W+1/8/3  downstream read address.
- s_aw_{valid,ready,addr,id,len,size}  out/in/out/out/out/out  1/1/ADDR_W/ID_W+1/8/3  downstream write address.
- s_w_{valid,ready,data,last}  out/in/out/out  1/1/DATA_W/1  downstream write data.
- s_b_{valid,ready,id,resp}  in/out/in/in  1/1/ID_W+1/2  downstream write response.
- s_r_{valid,ready,data,id,resp,last}  in/out/in/in/in/in  1/1/DATA_W/ID_W+1/2/1  downstream read data.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values:
  - all valid outputs 0;
  - ar_ptr = aw_ptr = 0 (requester 0 has priority first);
  - ar_lock = aw_lock = 0;
  - W FIFO empty.
- AR arbiter (aw identical with its own state):
  - Idle, ar_lock=0: grant = ar_ptr if that requester is valid, else the other requester.
  - s_ar_valid = OR of the requester valids, asserted in the same cycle (zero-latency pass-through).
  - s_ar_id = {grant, mN_ar_id}.
  - If s_ar_valid && !s_ar_ready, set ar_lock and register the grant. The grant then holds until handshake, so AXI stability holds even if the other requester asserts.
  - On handshake: clear lock, set ar_ptr = ~grant.
  - Only the granted requester sees ready = s_ar_ready.
- AW extra rule: s_aw_valid is also gated by !wq_full. mN_aw_ready = 0 while the FIFO is full. Each AW handshake pushes the grant index into the W FIFO.
- W routing:
  - Head of FIFO selects the requester. s_w_* is muxed from it; mN_w_ready = s_w_ready only for the head requester.
  - FIFO empty: s_w_valid=0 and both w_ready=0 (W before AW stalls).
  - Pop on s_w handshake with last=1.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - AW handshake and first W beat may complete in the same cycle only when the FIFO was already non-empty for an earlier burst. There is no combinational bypass from push to head.
- R steering:
  - sel = s_r_id[ID_W]; mN_r_valid = s_r_valid && sel==N.
  - mN_r_id = s_r_id[ID_W-1:0]; s_r_ready = m{sel}_r_ready.
  - Data, resp and last pass through combinationally. No buffering and no reordering.
- B steering: same scheme as R, on s_b_id.
- No timeouts. Responses with any ID are routed; no illegal-ID handling.
- Reset mid-transaction:
  - all state clears, and in-flight bursts are abandoned;
  - the downstream slave must be reset by the same reset;
  - the system drives reset = !FCLK_RESET0_N || !mmcm_locked.
- Arbitration is per address transaction. Burst length does not affect AR fairness.

Decomposition:
- Package nasti_arb_pkg:
  - ADDR_W/DATA_W/ID_W defaults;
  - localparam SID_W = ID_W+1;
  - requester-index typedef (1 bit);
  - NASTI resp encodings (OKAY=2'b00, SLVERR=2'b10).
- Sub-module nasti_arb_wfifo:
  - synchronous FIFO of 1-bit requester indices, WQ_DEPTH entries;
  - ports clk, reset, push, push_data, pop, head, empty, full.
- The two round-robin address arbiters are written as one generate/instantiated pair, or inline. No further sub-modules.

Test Plan:
- Both mN_ar_valid high at cycle 0 after reset, s_ar_ready=1 -> requester 0 granted first with s_ar_id={1'b0,id}; requester 1 granted in cycle 1 with s_ar_id={1'b1,id}.
- m1 ar valid, s_ar_ready low for 3 cycles while m0 asserts in cycle 1 -> s_ar_addr/id stay m1's for all 4 cycles; m0 granted only after the m1 handshake.
- AW from m0 (len=3), then m1 (len=1), with W beats from both presented at once -> s_w carries 4 m0 beats then 2 m1 beats; m1_w_ready=0 until m0's last beat pops.
- Four AW accepted with s_w_ready=0 (WQ_DEPTH=4) -> fifth AW sees mN_aw_ready=0 and s_aw_valid=0; first W last-beat pop re-enables it.
- s_r with id=6'b1_00101 and m1_r_ready=0 -> m1_r_valid=1, m1_r_id=5'h05, s_r_ready=0, m0_r_valid=0. Same for s_b with top bit 0 -> routed to m0.
- Assert reset for 1 cycle mid-burst (FIFO holding 2 entries, ar_lock set) -> next cycle all valids 0, FIFO empty, ar_ptr=0.

Source files
------------

// File: rtl/nasti_arb_pkg.sv
// Shared defaults and types for the two-requester NASTI slave-port arbiter.
package nasti_arb_pkg;
  localparam int unsigned NASTI_ADDR_W = 32;
  localparam int unsigned NASTI_DATA_W = 64;
  localparam int unsigned NASTI_ID_W   = 5;
  localparam int unsigned SID_W        = NASTI_ID_W + 1;

  typedef logic req_idx_t;

  typedef enum logic [1:0] {
    NASTI_RESP_OKAY   = 2'b00,
    NASTI_RESP_SLVERR = 2'b10
  } nasti_resp_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;
endpackage

// File: rtl/nasti_arb_wfifo.sv
// W routing FIFO: holds the requester index of each accepted AW burst, in
// grant order, until that burst's last W beat leaves.
module nasti_arb_wfifo
  import nasti_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  req_idx_t push_data,
  input  logic     pop,
  output req_idx_t head,
  output logic     empty,
  output logic     full
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  req_idx_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_COUNT);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/nasti_slave_arbiter.sv
// Shares one NASTI slave port between two requesters: round-robin AR/AW,
// W routed in AW grant order, R/B steered back by a prepended ID bit.
module nasti_slave_arbiter
  import nasti_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = NASTI_ADDR_W,
  parameter int unsigned DATA_W   = NASTI_DATA_W,
  parameter int unsigned ID_W     = NASTI_ID_W,
  parameter int unsigned WQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              m0_ar_valid,
  output logic              m0_ar_ready,
  input  logic [ADDR_W-1:0] m0_ar_addr,
  input  logic [ID_W-1:0]   m0_ar_id,
  input  logic [7:0]        m0_ar_len,
  input  logic [2:0]        m0_ar_size,
  input  logic              m0_aw_valid,
  output logic              m0_aw_ready,
  input  logic [ADDR_W-1:0] m0_aw_addr,
  input  logic [ID_W-1:0]   m0_aw_id,
  input  logic [7:0]        m0_aw_len,
  input  logic [2:0]        m0_aw_size,
  input  logic              m0_w_valid,
  output logic              m0_w_ready,
  input  logic [DATA_W-1:0] m0_w_data,
  input  logic              m0_w_last,
  output logic              m0_b_valid,
  input  logic              m0_b_ready,
  output logic [ID_W-1:0]   m0_b_id,
  output logic [1:0]        m0_b_resp,
  output logic              m0_r_valid,
  input  logic              m0_r_ready,
  output logic [DATA_W-1:0] m0_r_data,
  output logic [ID_W-1:0]   m0_r_id,
  output logic [1:0]        m0_r_resp,
  output logic              m0_r_last,
  // requester 1
  input  logic              m1_ar_valid,
  output logic              m1_ar_ready,
  input  logic [ADDR_W-1:0] m1_ar_addr,
  input  logic [ID_W-1:0]   m1_ar_id,
  input  logic [7:0]        m1_ar_len,
  input  logic [2:0]        m1_ar_size,
  input  logic              m1_aw_valid,
  output logic              m1_aw_ready,
  input  logic [ADDR_W-1:0] m1_aw_addr,
  input  logic [ID_W-1:0]   m1_aw_id,
  input  logic [7:0]        m1_aw_len,
  input  logic [2:0]        m1_aw_size,
  input  logic              m1_w_valid,
  output logic              m1_w_ready,
  input  logic [DATA_W-1:0] m1_w_data,
  input  logic              m1_w_last,
  output logic              m1_b_valid,
  input  logic              m1_b_ready,
  output logic [ID_W-1:0]   m1_b_id,
  output logic [1:0]        m1_b_resp,
  output logic              m1_r_valid,
  input  logic              m1_r_ready,
  output logic [DATA_W-1:0] m1_r_data,
  output logic [ID_W-1:0]   m1_r_id,
  output logic [1:0]        m1_r_resp,
  output logic              m1_r_last,
  // downstream slave
  output logic              s_ar_valid,
  input  logic              s_ar_ready,
  output logic [ADDR_W-1:0] s_ar_addr,
  output logic [ID_W:0]     s_ar_id,
  output logic [7:0]        s_ar_len,
  output logic [2:0]        s_ar_size,
  output logic              s_aw_valid,
  input  logic              s_aw_ready,
  output logic [ADDR_W-1:0] s_aw_addr,
  output logic [ID_W:0]     s_aw_id,
  output logic [7:0]        s_aw_len,
  output logic [2:0]        s_aw_size,
  output logic              s_w_valid,
  input  logic              s_w_ready,
  output logic [DATA_W-1:0] s_w_data,
  output logic              s_w_last,
  input  logic              s_b_valid,
  output logic              s_b_ready,
  input  logic [ID_W:0]     s_b_id,
  input  logic [1:0]        s_b_resp,
  input  logic              s_r_valid,
  output logic              s_r_ready,
  input  logic [DATA_W-1:0] s_r_data,
  input  logic [ID_W:0]     s_r_id,
  input  logic [1:0]        s_r_resp,
  input  logic              s_r_last
);
  arb_state_e ar_state, aw_state;
  req_idx_t   ar_ptr, aw_ptr;
  req_idx_t   ar_grant_q, aw_grant_q;
  req_idx_t   ar_grant, aw_grant;
  logic       ar_hs, aw_hs;
  logic       wq_full, wq_empty, w_pop;
  req_idx_t   w_head;
  req_idx_t   r_sel, b_sel;

  // Idle: the pointed-to requester wins if valid, otherwise the other one.
  // Locked: the registered grant holds until the downstream handshake.
  always_comb begin
    ar_grant = ar_grant_q;
    if (ar_state == ARB_IDLE) ar_grant = ar_ptr ? m1_ar_valid : !m0_ar_valid;
  end

  always_comb begin
    aw_grant = aw_grant_q;
    if (aw_state == ARB_IDLE) aw_grant = aw_ptr ? m1_aw_valid : !m0_aw_valid;
  end

  assign s_ar_valid  = m0_ar_valid || m1_ar_valid;
  assign s_ar_addr   = ar_grant ? m1_ar_addr : m0_ar_addr;
  assign s_ar_id     = {ar_grant, ar_grant ? m1_ar_id : m0_ar_id};
  assign s_ar_len    = ar_grant ? m1_ar_len : m0_ar_len;
  assign s_ar_size   = ar_grant ? m1_ar_size : m0_ar_size;
  assign m0_ar_ready = s_ar_ready && !ar_grant;
  assign m1_ar_ready = s_ar_ready && ar_grant;
  assign ar_hs       = s_ar_valid && s_ar_ready;

  // AW stalls while the W routing FIFO cannot record another burst.
  assign s_aw_valid  = (m0_aw_valid || m1_aw_valid) && !wq_full;
  assign s_aw_addr   = aw_grant ? m1_aw_addr : m0_aw_addr;
  assign s_aw_id     = {aw_grant, aw_grant ? m1_aw_id : m0_aw_id};
  assign s_aw_len    = aw_grant ? m1_aw_len : m0_aw_len;
  assign s_aw_size   = aw_grant ? m1_aw_size : m0_aw_size;
  assign m0_aw_ready = s_aw_ready && !wq_full && !aw_grant;
  assign m1_aw_ready = s_aw_ready && !wq_full && aw_grant;
  assign aw_hs       = s_aw_valid && s_aw_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state   <= ARB_IDLE;
      ar_ptr     <= '0;
      ar_grant_q <= '0;
    end else if (ar_hs) begin
      ar_state <= ARB_IDLE;
      ar_ptr   <= ~ar_grant;
    end else if (s_ar_valid) begin
      ar_state   <= ARB_LOCKED;
      ar_grant_q <= ar_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aw_state   <= ARB_IDLE;
      aw_ptr     <= '0;
      aw_grant_q <= '0;
    end else if (aw_hs) begin
      aw_state <= ARB_IDLE;
      aw_ptr   <= ~aw_grant;
    end else if (s_aw_valid) begin
      aw_state   <= ARB_LOCKED;
      aw_grant_q <= aw_grant;
    end
  end

  nasti_arb_wfifo #(
    .DEPTH (WQ_DEPTH)
  ) u_wfifo (
    .clk       (clk),
    .reset     (reset),
    .push      (aw_hs),
    .push_data (aw_grant),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (wq_empty),
    .full      (wq_full)
  );

  assign s_w_valid  = !wq_empty && (w_head ? m1_w_valid : m0_w_valid);
  assign s_w_data   = w_head ? m1_w_data : m0_w_data;
  assign s_w_last   = w_head ? m1_w_last : m0_w_last;
  assign m0_w_ready = s_w_ready && !wq_empty && !w_head;
  assign m1_w_ready = s_w_ready && !wq_empty && w_head;
  assign w_pop      = s_w_valid && s_w_ready && s_w_last;

  assign r_sel      = s_r_id[ID_W];
  assign m0_r_valid = s_r_valid && !r_sel;
  assign m1_r_valid = s_r_valid && r_sel;
  assign s_r_ready  = r_sel ? m1_r_ready : m0_r_ready;
  assign m0_r_data  = s_r_data;
  assign m1_r_data  = s_r_data;
  assign m0_r_id    = s_r_id[ID_W-1:0];
  assign m1_r_id    = s_r_id[ID_W-1:0];
  assign m0_r_resp  = s_r_resp;
  assign m1_r_resp  = s_r_resp;
  assign m0_r_last  = s_r_last;
  assign m1_r_last  = s_r_last;

  assign b_sel      = s_b_id[ID_W];
  assign m0_b_valid = s_b_valid && !b_sel;
  assign m1_b_valid = s_b_valid && b_sel;
  assign s_b_ready  = b_sel ? m1_b_ready : m0_b_ready;
  assign m0_b_id    = s_b_id[ID_W-1:0];
  assign m1_b_id    = s_b_id[ID_W-1:0];
  assign m0_b_resp  = s_b_resp;
  assign m1_b_resp  = s_b_resp;
endmodule

// File: tb/tb_nasti_slave_arbiter.sv
// Directed bench for nasti_slave_arbiter: AR/AW/W scoreboards fed at stimulus
// time and drained on downstream handshakes, plus point checks on steering.
module tb_nasti_slave_arbiter;
  import nasti_arb_pkg::*;

  localparam int unsigned A_W = 32;
  localparam int unsigned D_W = 64;
  localparam int unsigned I_W = 5;

  typedef struct packed {
    logic [A_W-1:0] addr;
    logic [I_W:0]   id;
    logic [7:0]     len;
  } addr_t;

  typedef struct packed {
    logic [D_W-1:0] data;
    logic           last;
  } wbeat_t;

  logic clk = 1'b0;
  logic reset;

  logic m0_ar_valid, m0_ar_ready, m1_ar_valid, m1_ar_ready;
  logic [A_W-1:0] m0_ar_addr, m1_ar_addr;
  logic [I_W-1:0] m0_ar_id, m1_ar_id;
  logic [7:0] m0_ar_len, m1_ar_len;
  logic [2:0] m0_ar_size, m1_ar_size;
  logic m0_aw_valid, m0_aw_ready, m1_aw_valid, m1_aw_ready;
  logic [A_W-1:0] m0_aw_addr, m1_aw_addr;
  logic [I_W-1:0] m0_aw_id, m1_aw_id;
  logic [7:0] m0_aw_len, m1_aw_len;
  logic [2:0] m0_aw_size, m1_aw_size;
  logic m0_w_valid, m0_w_ready, m0_w_last, m1_w_valid, m1_w_ready, m1_w_last;
  logic [D_W-1:0] m0_w_data, m1_w_data;
  logic m0_b_valid, m0_b_ready, m1_b_valid, m1_b_ready;
  logic [I_W-1:0] m0_b_id, m1_b_id;
  logic [1:0] m0_b_resp, m1_b_resp;
  logic m0_r_valid, m0_r_ready, m0_r_last, m1_r_valid, m1_r_ready, m1_r_last;
  logic [D_W-1:0] m0_r_data, m1_r_data;
  logic [I_W-1:0] m0_r_id, m1_r_id;
  logic [1:0] m0_r_resp, m1_r_resp;
  logic s_ar_valid, s_ar_ready, s_aw_valid, s_aw_ready;
  logic [A_W-1:0] s_ar_addr, s_aw_addr;
  logic [I_W:0] s_ar_id, s_aw_id, s_b_id, s_r_id;
  logic [7:0] s_ar_len, s_aw_len;
  logic [2:0] s_ar_size, s_aw_size;
  logic s_w_valid, s_w_ready, s_w_last;
  logic [D_W-1:0] s_w_data, s_r_data;
  logic s_b_valid, s_b_ready, s_r_valid, s_r_ready, s_r_last;
  logic [1:0] s_b_resp, s_r_resp;

  int checks = 0;
  int failures = 0;
  addr_t  ar_q[$];
  addr_t  aw_q[$];
  wbeat_t w_q[$];

  always #5 clk = ~clk;

  nasti_slave_arbiter #(
    .ADDR_W (A_W), .DATA_W (D_W), .ID_W (I_W), .WQ_DEPTH (4)
  ) dut (
    .clk (clk), .reset (reset),
    .m0_ar_valid (m0_ar_valid), .m0_ar_ready (m0_ar_ready), .m0_ar_addr (m0_ar_addr),
    .m0_ar_id (m0_ar_id), .m0_ar_len (m0_ar_len), .m0_ar_size (m0_ar_size),
    .m0_aw_valid (m0_aw_valid), .m0_aw_ready (m0_aw_ready), .m0_aw_addr (m0_aw_addr),
    .m0_aw_id (m0_aw_id), .m0_aw_len (m0_aw_len), .m0_aw_size (m0_aw_size),
    .m0_w_valid (m0_w_valid), .m0_w_ready (m0_w_ready), .m0_w_data (m0_w_data),
    .m0_w_last (m0_w_last),
    .m0_b_valid (m0_b_valid), .m0_b_ready (m0_b_ready), .m0_b_id (m0_b_id),
    .m0_b_resp (m0_b_resp),
    .m0_r_valid (m0_r_valid), .m0_r_ready (m0_r_ready), .m0_r_data (m0_r_data),
    .m0_r_id (m0_r_id), .m0_r_resp (m0_r_resp), .m0_r_last (m0_r_last),
    .m1_ar_valid (m1_ar_valid), .m1_ar_ready (m1_ar_ready), .m1_ar_addr (m1_ar_addr),
    .m1_ar_id (m1_ar_id), .m1_ar_len (m1_ar_len), .m1_ar_size (m1_ar_size),
    .m1_aw_valid (m1_aw_valid), .m1_aw_ready (m1_aw_ready), .m1_aw_addr (m1_aw_addr),
    .m1_aw_id (m1_aw_id), .m1_aw_len (m1_aw_len), .m1_aw_size (m1_aw_size),
    .m1_w_valid (m1_w_valid), .m1_w_ready (m1_w_ready), .m1_w_data (m1_w_data),
    .m1_w_last (m1_w_last),
    .m1_b_valid (m1_b_valid), .m1_b_ready (m1_b_ready), .m1_b_id (m1_b_id),
    .m1_b_resp (m1_b_resp),
    .m1_r_valid (m1_r_valid), .m1_r_ready (m1_r_ready), .m1_r_data (m1_r_data),
    .m1_r_id (m1_r_id), .m1_r_resp (m1_r_resp), .m1_r_last (m1_r_last),
    .s_ar_valid (s_ar_valid), .s_ar_ready (s_ar_ready), .s_ar_addr (s_ar_addr),
    .s_ar_id (s_ar_id), .s_ar_len (s_ar_len), .s_ar_size (s_ar_size),
    .s_aw_valid (s_aw_valid), .s_aw_ready (s_aw_ready), .s_aw_addr (s_aw_addr),
    .s_aw_id (s_aw_id), .s_aw_len (s_aw_len), .s_aw_size (s_aw_size),
    .s_w_valid (s_w_valid), .s_w_ready (s_w_ready), .s_w_data (s_w_data),
    .s_w_last (s_w_last),
    .s_b_valid (s_b_valid), .s_b_ready (s_b_ready), .s_b_id (s_b_id),
    .s_b_resp (s_b_resp),
    .s_r_valid (s_r_valid), .s_r_ready (s_r_ready), .s_r_data (s_r_data),
    .s_r_id (s_r_id), .s_r_resp (s_r_resp), .s_r_last (s_r_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    m0_ar_valid = 0; m0_ar_addr = '0; m0_ar_id = '0; m0_ar_len = '0; m0_ar_size = '0;
    m1_ar_valid = 0; m1_ar_addr = '0; m1_ar_id = '0; m1_ar_len = '0; m1_ar_size = '0;
    m0_aw_valid = 0; m0_aw_addr = '0; m0_aw_id = '0; m0_aw_len = '0; m0_aw_size = '0;
    m1_aw_valid = 0; m1_aw_addr = '0; m1_aw_id = '0; m1_aw_len = '0; m1_aw_size = '0;
    m0_w_valid = 0; m0_w_data = '0; m0_w_last = 0;
    m1_w_valid = 0; m1_w_data = '0; m1_w_last = 0;
    m0_b_ready = 0; m1_b_ready = 0; m0_r_ready = 0; m1_r_ready = 0;
    s_ar_ready = 0; s_aw_ready = 0; s_w_ready = 0;
    s_b_valid = 0; s_b_id = '0; s_b_resp = '0;
    s_r_valid = 0; s_r_id = '0; s_r_data = '0; s_r_resp = '0; s_r_last = 0;
  endtask

  // Scoreboards drain on downstream handshakes, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (s_ar_valid && s_ar_ready) begin
        chk("ar_expected", ar_q.size() != 0, 1'b1);
        if (ar_q.size() != 0) begin
          addr_t e;
          e = ar_q.pop_front();
          chk("ar_addr", s_ar_addr, e.addr);
          chk("ar_id", s_ar_id, e.id);
          chk("ar_len", s_ar_len, e.len);
        end
      end
      if (s_aw_valid && s_aw_ready) begin
        chk("aw_expected", aw_q.size() != 0, 1'b1);
        if (aw_q.size() != 0) begin
          addr_t e;
          e = aw_q.pop_front();
          chk("aw_addr", s_aw_addr, e.addr);
          chk("aw_id", s_aw_id, e.id);
          chk("aw_len", s_aw_len, e.len);
        end
      end
      if (s_w_valid && s_w_ready) begin
        chk("w_expected", w_q.size() != 0, 1'b1);
        if (w_q.size() != 0) begin
          wbeat_t e;
          e = w_q.pop_front();
          chk("w_data", s_w_data, e.data);
          chk("w_last", s_w_last, e.last);
        end
      end
    end
  end

  initial begin
    logic aw0_pend, aw1_pend, hs_aw0, hs_aw1, hs_w0, hs_w1;
    int   b0, b1, cyc;

    clear_inputs();
    reset = 1;
    repeat (2) tick();
    reset = 0;

    // Reset state; a W beat with no AW ahead of it must stall.
    m0_w_valid = 1; m0_w_last = 1; m0_w_data = 64'h1; s_w_ready = 1;
    settle();
    chk("rst_s_ar_valid", s_ar_valid, 0);
    chk("rst_s_aw_valid", s_aw_valid, 0);
    chk("rst_w_stall_valid", s_w_valid, 0);
    chk("rst_w_stall_ready", m0_w_ready, 0);
    chk("rst_m0_r_valid", m0_r_valid, 0);
    tick();
    clear_inputs();

    // Round robin: both request at once, requester 0 first.
    m0_ar_valid = 1; m0_ar_addr = 32'h1000; m0_ar_id = 5'd3; m0_ar_len = 8'd7; m0_ar_size = 3'd3;
    m1_ar_valid = 1; m1_ar_addr = 32'h2000; m1_ar_id = 5'd7; m1_ar_len = 8'd0; m1_ar_size = 3'd3;
    s_ar_ready = 1;
    ar_q.push_back('{addr: 32'h1000, id: {1'b0, 5'd3}, len: 8'd7});
    ar_q.push_back('{addr: 32'h2000, id: {1'b1, 5'd7}, len: 8'd0});
    settle();
    chk("ar_rr_first_id", s_ar_id, {1'b0, 5'd3});
    chk("ar_rr_m1_ready", m1_ar_ready, 0);
    tick();
    m0_ar_valid = 0;
    settle();
    chk("ar_rr_second_id", s_ar_id, {1'b1, 5'd7});
    chk("ar_rr_m1_ready2", m1_ar_ready, 1);
    tick();
    clear_inputs();

    // Lock: m1 stalled three cycles while m0 arrives in the second.
    m1_ar_valid = 1; m1_ar_addr = 32'h3000; m1_ar_id = 5'h11; m1_ar_len = 8'd3;
    ar_q.push_back('{addr: 32'h3000, id: {1'b1, 5'h11}, len: 8'd3});
    ar_q.push_back('{addr: 32'h4000, id: {1'b0, 5'h02}, len: 8'd1});
    for (int c = 0; c < 4; c++) begin
      if (c == 1) begin
        m0_ar_valid = 1; m0_ar_addr = 32'h4000; m0_ar_id = 5'h02; m0_ar_len = 8'd1;
      end
      s_ar_ready = (c == 3);
      settle();
      chk("ar_lock_addr", s_ar_addr, 32'h3000);
      chk("ar_lock_id", s_ar_id, {1'b1, 5'h11});
      chk("ar_lock_m0_ready", m0_ar_ready, 0);
      tick();
    end
    m1_ar_valid = 0;
    settle();
    chk("ar_after_lock_id", s_ar_id, {1'b0, 5'h02});
    tick();
    clear_inputs();

    // W follows AW order: m0 4 beats then m1 2 beats, both presented together.
    s_aw_ready = 1; s_w_ready = 1;
    aw_q.push_back('{addr: 32'h5000, id: {1'b0, 5'h01}, len: 8'd3});
    aw_q.push_back('{addr: 32'h6000, id: {1'b1, 5'h02}, len: 8'd1});
    for (int b = 0; b < 4; b++) w_q.push_back('{data: 64'hA000_0000_0000_0000 + 64'(b), last: b == 3});
    for (int b = 0; b < 2; b++) w_q.push_back('{data: 64'hB000_0000_0000_0000 + 64'(b), last: b == 1});
    aw0_pend = 1; aw1_pend = 1; b0 = 0; b1 = 0; cyc = 0;
    while ((aw0_pend || aw1_pend || b0 < 4 || b1 < 2) && cyc < 40) begin
      m0_aw_valid = aw0_pend; m0_aw_addr = 32'h5000; m0_aw_id = 5'h01; m0_aw_len = 8'd3;
      m1_aw_valid = aw1_pend; m1_aw_addr = 32'h6000; m1_aw_id = 5'h02; m1_aw_len = 8'd1;
      m0_w_valid = (b0 < 4); m0_w_data = 64'hA000_0000_0000_0000 + 64'(b0); m0_w_last = (b0 == 3);
      m1_w_valid = (b1 < 2); m1_w_data = 64'hB000_0000_0000_0000 + 64'(b1); m1_w_last = (b1 == 1);
      settle();
      if (b0 < 4) chk("w_m1_blocked", m1_w_ready, 0);
      else if (b1 < 2) chk("w_m1_head_ready", m1_w_ready, 1);
      hs_aw0 = m0_aw_valid && m0_aw_ready;
      hs_aw1 = m1_aw_valid && m1_aw_ready;
      hs_w0  = m0_w_valid && m0_w_ready;
      hs_w1  = m1_w_valid && m1_w_ready;
      tick();
      if (hs_aw0) aw0_pend = 0;
      if (hs_aw1) aw1_pend = 0;
      if (hs_w0) b0++;
      if (hs_w1) b1++;
      cyc++;
    end
    chk("w_order_within_budget", cyc < 40, 1);
    clear_inputs();

    // Fill the W FIFO with four bursts while W is stalled.
    s_aw_ready = 1;
    for (int i = 0; i < 4; i++) begin
      m0_aw_valid = 1; m0_aw_addr = 32'h7000 + 32'(i) * 32'h100; m0_aw_id = 5'(i); m0_aw_len = 8'd0;
      aw_q.push_back('{addr: 32'h7000 + 32'(i) * 32'h100, id: {1'b0, 5'(i)}, len: 8'd0});
      settle();
      chk("aw_fill_ready", m0_aw_ready, 1);
      tick();
    end
    m0_aw_addr = 32'h7400; m0_aw_id = 5'd4;
    m0_w_valid = 1; m0_w_data = 64'hC0; m0_w_last = 1; s_w_ready = 1;
    w_q.push_back('{data: 64'hC0, last: 1'b1});
    settle();
    chk("aw_full_ready", m0_aw_ready, 0);
    chk("aw_full_s_valid", s_aw_valid, 0);
    chk("aw_full_w_ready", m0_w_ready, 1);
    tick();
    m0_w_valid = 0;
    aw_q.push_back('{addr: 32'h7400, id: {1'b0, 5'd4}, len: 8'd0});
    settle();
    chk("aw_refill_s_valid", s_aw_valid, 1);
    chk("aw_refill_ready", m0_aw_ready, 1);
    tick();
    m0_aw_valid = 0;
    for (int i = 0; i < 2; i++) begin
      m0_w_valid = 1; m0_w_data = 64'hD0 + 64'(i); m0_w_last = 1;
      w_q.push_back('{data: 64'hD0 + 64'(i), last: 1'b1});
      settle();
      chk("w_drain_ready", m0_w_ready, 1);
      tick();
    end
    clear_inputs();

    // R and B steering by the prepended ID bit.
    s_r_valid = 1; s_r_id = 6'b1_00101; s_r_data = 64'hDEAD_BEEF_0123_4567;
    s_r_resp = NASTI_RESP_OKAY; s_r_last = 1; m0_r_ready = 1; m1_r_ready = 0;
    settle();
    chk("r_m1_valid", m1_r_valid, 1);
    chk("r_m1_id", m1_r_id, 5'h05);
    chk("r_s_ready_low", s_r_ready, 0);
    chk("r_m0_valid", m0_r_valid, 0);
    chk("r_m1_data", m1_r_data, 64'hDEAD_BEEF_0123_4567);
    chk("r_m1_last", m1_r_last, 1);
    m1_r_ready = 1;
    #1;
    chk("r_s_ready_high", s_r_ready, 1);
    s_r_valid = 0;
    s_b_valid = 1; s_b_id = 6'b0_01010; s_b_resp = NASTI_RESP_SLVERR; m0_b_ready = 1; m1_b_ready = 0;
    #1;
    chk("b_m0_valid", m0_b_valid, 1);
    chk("b_m0_id", m0_b_id, 5'h0A);
    chk("b_m0_resp", m0_b_resp, 2'b10);
    chk("b_m1_valid", m1_b_valid, 0);
    chk("b_s_ready_high", s_b_ready, 1);
    m0_b_ready = 0;
    #1;
    chk("b_s_ready_low", s_b_ready, 0);
    clear_inputs();
    tick();

    // Reset mid-flight: AR locked on m1, two W bursts still queued.
    m1_ar_valid = 1; m1_ar_addr = 32'h8000; m1_ar_id = 5'd9;
    settle();
    chk("pre_rst_grant_m1", s_ar_id[I_W], 1);
    tick();
    reset = 1;
    m1_ar_valid = 0;
    m0_w_valid = 1; m0_w_data = 64'hE0; m0_w_last = 1; s_w_ready = 0;
    tick();
    reset = 0;
    m0_ar_valid = 1; m0_ar_addr = 32'h9000; m0_ar_id = 5'd3;
    m1_ar_valid = 1;
    s_w_ready = 1;
    settle();
    chk("post_rst_s_w_valid", s_w_valid, 0);
    chk("post_rst_m0_w_ready", m0_w_ready, 0);
    chk("post_rst_ar_grant", s_ar_id, {1'b0, 5'd3});
    chk("post_rst_s_aw_valid", s_aw_valid, 0);
    ar_q.push_back('{addr: 32'h9000, id: {1'b0, 5'd3}, len: 8'd0});
    s_ar_ready = 1;
    tick();
    clear_inputs();
    tick();

    chk("ar_q_drained", ar_q.size(), 0);
    chk("aw_q_drained", aw_q.size(), 0);
    chk("w_q_drained", w_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
